// File: rtl/stats_pkg.sv
// Shared constants and FSM state type for the stats packet generator.
package stats_pkg;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned RULE_W = 16;
    localparam int unsigned LANES  = DATA_W / RULE_W;
    localparam int unsigned LEN_W  = 16;

    localparam logic [15:0] RULE_TAG = 16'h8000;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} gen_state_t;

endpackage

// File: rtl/rule_lane_fill.sv
// Combinational payload builder: first `count` lanes carry tagged, consecutive rule IDs.
module rule_lane_fill
    import stats_pkg::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned RULE_W = 16
) (
    input  logic [14:0]       base,
    input  logic [5:0]        count,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned NUM_LANES = DATA_W / RULE_W;

    always_comb begin
        data = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            // The tag bit keeps every populated lane nonzero, even when the ID wraps to 0.
            if (i < int'(count)) begin
                data[i*RULE_W +: RULE_W] = RULE_W'(RULE_TAG | 16'(base + 15'(i)));
            end
        end
    end

endmodule

// File: rtl/stats_pkt_gen.sv
// Packet stream generator with valid/ready handshake and its own sent-flit/packet/rule counts.
module stats_pkt_gen #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned RULE_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [31:0]       num_pkt,
    input  logic [LEN_W-1:0]  flits_per_pkt,
    input  logic [5:0]        rules_per_flit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sent_flit,
    output logic [31:0]       sent_pkt,
    output logic [31:0]       sent_rule
);

    import stats_pkg::*;

    localparam int unsigned NUM_LANES = DATA_W / RULE_W;

    gen_state_t        state_q;
    logic [31:0]       num_pkt_q;
    logic [LEN_W-1:0]  last_idx_q;
    logic [5:0]        rpf_q;
    logic [31:0]       pkt_cnt_q;
    logic [LEN_W-1:0]  flit_idx_q;
    logic [14:0]       base_q;

    logic              acc;
    logic              first;
    logic              last_flit;
    logic [14:0]       base_nxt;
    logic [LEN_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] fill_data;

    always_comb begin
        acc       = out_valid & out_ready;
        first     = (state_q == SEND) && !out_valid;
        base_nxt  = (acc && !out_eop) ? base_q + 15'(rpf_q) : base_q;
        idx_nxt   = (first || out_eop) ? '0 : flit_idx_q + LEN_W'(1);
        last_flit = acc && out_eop && (pkt_cnt_q == num_pkt_q - 32'd1);
    end

    // Payload is built from the post-accept base so the next flit can follow with no bubble.
    rule_lane_fill #(
        .DATA_W (DATA_W),
        .RULE_W (RULE_W)
    ) u_fill (
        .base  (base_nxt),
        .count (rpf_q),
        .data  (fill_data)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            num_pkt_q  <= '0;
            last_idx_q <= '0;
            rpf_q      <= '0;
            pkt_cnt_q  <= '0;
            flit_idx_q <= '0;
            base_q     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_flit  <= '0;
            sent_pkt   <= '0;
            sent_rule  <= '0;
        end else begin
            done   <= 1'b0;
            base_q <= base_nxt;
            if (acc) begin
                sent_flit <= sent_flit + 32'd1;
                if (out_eop) begin
                    sent_pkt <= sent_pkt + 32'd1;
                end else begin
                    sent_rule <= sent_rule + 32'(rpf_q);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_pkt_q  <= num_pkt;
                        last_idx_q <= (flits_per_pkt == '0) ? '0 : flits_per_pkt - LEN_W'(1);
                        rpf_q      <= (rules_per_flit > 6'(NUM_LANES)) ? 6'(NUM_LANES)
                                                                       : rules_per_flit;
                        busy       <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    pkt_cnt_q <= '0;
                    if (num_pkt_q == '0) begin
                        done    <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (first || (acc && !last_flit)) begin
                        out_valid  <= 1'b1;
                        out_sop    <= (idx_nxt == '0);
                        out_eop    <= (idx_nxt == last_idx_q);
                        out_data   <= (idx_nxt == last_idx_q) ? '0 : fill_data;
                        flit_idx_q <= idx_nxt;
                        if (acc && out_eop) begin
                            pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        end
                    end else if (last_flit) begin
                        out_valid <= 1'b0;
                        out_sop   <= 1'b0;
                        out_eop   <= 1'b0;
                        out_data  <= '0;
                        done      <= 1'b1;
                        state_q   <= FIN;
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stats_pkt_gen.sv
// Self-checking bench for stats_pkt_gen: scoreboard of expected flits plus counter/FSM checks.
module tb_stats_pkt_gen;

    logic         Clk;
    logic         Rst;
    logic         start;
    logic [31:0]  num_pkt;
    logic [15:0]  flits_per_pkt;
    logic [5:0]   rules_per_flit;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic [31:0]  sent_flit;
    logic [31:0]  sent_pkt;
    logic [31:0]  sent_rule;

    stats_pkt_gen dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .start          (start),
        .num_pkt        (num_pkt),
        .flits_per_pkt  (flits_per_pkt),
        .rules_per_flit (rules_per_flit),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .sent_flit      (sent_flit),
        .sent_pkt       (sent_pkt),
        .sent_rule      (sent_rule)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
    } exp_t;

    typedef struct {
        int np;
        int fpp;
        int rpf;
        bit rnd;
        int ef;
        int ep;
        int er;
    } vec_t;

    exp_t         q[$];
    int           n_total = 0;
    int           n_bad = 0;
    logic [14:0]  mbase = '0;
    bit           mon_en = 1'b1;
    bit           rnd_mode = 1'b0;
    bit           cap_first = 1'b0;
    logic [511:0] first_data;
    bit           held_v = 1'b0;
    logic [511:0] held_data;
    logic [1:0]   held_ctl;
    longint       tot_f, tot_p, tot_r;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic logic [511:0] exp_fill(input logic [14:0] b, input int n);
        logic [511:0] d;
        logic [14:0]  v;
        d = '0;
        for (int i = 0; i < n; i++) begin
            v = b + 15'(i);
            d[i*16 +: 16] = {1'b1, v};
        end
        return d;
    endfunction

    task automatic push_run(input int np, input int fpp, input int rpf);
        int   fe;
        int   re;
        exp_t e;
        fe = (fpp == 0) ? 1 : fpp;
        re = (rpf > 32) ? 32 : rpf;
        for (int p = 0; p < np; p++) begin
            for (int f = 0; f < fe; f++) begin
                e.sop  = (f == 0);
                e.eop  = (f == fe - 1);
                e.data = e.eop ? '0 : exp_fill(mbase, re);
                if (!e.eop) mbase = mbase + 15'(re);
                q.push_back(e);
            end
        end
    endtask

    // Config is scrambled right after the start pulse; the DUT must have latched it.
    task automatic start_run(input int np, input int fpp, input int rpf);
        push_run(np, fpp, rpf);
        num_pkt        = 32'(np);
        flits_per_pkt  = 16'(fpp);
        rules_per_flit = 6'(rpf);
        start          = 1'b1;
        @(posedge Clk); #1;
        start          = 1'b0;
        num_pkt        = 32'd99;
        flits_per_pkt  = 16'd7;
        rules_per_flit = 6'd1;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(posedge Clk); #1;
            c++;
        end
        check("done_seen", 512'(done), 512'(1));
        check("drain", 512'(q.size()), 512'(0));
        @(posedge Clk); #1;
        check("done_pulse", 512'(done), 512'(0));
        check("idle_busy", 512'(busy), 512'(0));
    endtask

    task automatic check_counts(input longint f, input longint p, input longint r);
        check("sent_flit", 512'(sent_flit), 512'(f));
        check("sent_pkt", 512'(sent_pkt), 512'(p));
        check("sent_rule", 512'(sent_rule), 512'(r));
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            out_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (!mon_en) begin
            held_v = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (held_v) begin
                check("hold_data", out_data, held_data);
                check("hold_ctl", 512'({out_sop, out_eop}), 512'(held_ctl));
            end
            if (out_ready) begin
                held_v = 1'b0;
                if (q.size() == 0) begin
                    check("extra_flit", 512'(1), 512'(0));
                end else begin
                    e = q.pop_front();
                    check("data", out_data, e.data);
                    check("sop", 512'(out_sop), 512'(e.sop));
                    check("eop", 512'(out_eop), 512'(e.eop));
                    if (cap_first) begin
                        first_data = out_data;
                        cap_first  = 1'b0;
                    end
                end
            end else begin
                held_v    = 1'b1;
                held_data = out_data;
                held_ctl  = {out_sop, out_eop};
            end
        end
    end

    vec_t tbl[6];

    initial begin
        int zeros;
        tbl[0] = '{3, 4, 32, 1'b0, 12, 3, 288};
        tbl[1] = '{5, 1, 7, 1'b0, 5, 5, 0};
        tbl[2] = '{2, 0, 3, 1'b0, 2, 2, 0};
        tbl[3] = '{4, 3, 5, 1'b1, 12, 4, 40};
        tbl[4] = '{2, 5, 40, 1'b1, 10, 2, 256};
        tbl[5] = '{3, 2, 0, 1'b0, 6, 3, 0};

        Rst = 1'b1;
        start = 1'b0;
        num_pkt = '0;
        flits_per_pkt = '0;
        rules_per_flit = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        check("rst_valid", 512'(out_valid), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_data", out_data, '0);
        check_counts(0, 0, 0);

        // Drive the rule base to 0x7FF0, then a clamped run whose lanes wrap 0xFFFF -> 0x8000.
        start_run(1, 1024, 32);
        wait_done(1200);
        start_run(1, 2, 16);
        wait_done(20);
        cap_first = 1'b1;
        start_run(1, 3, 40);
        wait_done(20);
        check("wrap_lane0", 512'(first_data[15:0]), 512'(16'hFFF0));
        check("wrap_lane15", 512'(first_data[255:240]), 512'(16'hFFFF));
        check("wrap_lane16", 512'(first_data[271:256]), 512'(16'h8000));
        check("wrap_lane31", 512'(first_data[511:496]), 512'(16'h800F));
        zeros = 0;
        for (int i = 0; i < 32; i++) if (first_data[i*16 +: 16] == 16'h0) zeros++;
        check("wrap_no_zero", 512'(zeros), 512'(0));
        check_counts(1029, 3, 32816);
        tot_f = 1029;
        tot_p = 3;
        tot_r = 32816;

        for (int k = 0; k < 6; k++) begin
            rnd_mode = tbl[k].rnd;
            start_run(tbl[k].np, tbl[k].fpp, tbl[k].rpf);
            wait_done(40 + 10 * tbl[k].ef);
            tot_f += tbl[k].ef;
            tot_p += tbl[k].ep;
            tot_r += tbl[k].er;
            check_counts(tot_f, tot_p, tot_r);
        end
        rnd_mode = 1'b0;

        // Empty run, with start re-pulsed while busy.
        num_pkt = 32'd0;
        flits_per_pkt = 16'd4;
        rules_per_flit = 6'd4;
        start = 1'b1;
        @(posedge Clk); #1;
        check("np0_load_busy", 512'(busy), 512'(1));
        check("np0_load_done", 512'(done), 512'(0));
        num_pkt = 32'd5;
        @(posedge Clk); #1;
        check("np0_fin_busy", 512'(busy), 512'(1));
        check("np0_fin_done", 512'(done), 512'(1));
        @(posedge Clk); #1;
        start = 1'b0;
        check("np0_idle_busy", 512'(busy), 512'(0));
        check("np0_idle_done", 512'(done), 512'(0));
        repeat (4) @(posedge Clk);
        #1;
        check("np0_no_valid", 512'(out_valid), 512'(0));
        check("np0_still_idle", 512'(busy), 512'(0));
        check_counts(tot_f, tot_p, tot_r);

        // Reset in the middle of a packet.
        start_run(3, 4, 8);
        repeat (5) @(posedge Clk);
        #1;
        check("pre_rst_valid", 512'(out_valid), 512'(1));
        mon_en = 1'b0;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("mid_rst_valid", 512'(out_valid), 512'(0));
        check("mid_rst_busy", 512'(busy), 512'(0));
        check("mid_rst_data", out_data, '0);
        check_counts(0, 0, 0);
        q.delete();
        mbase = '0;
        mon_en = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("no_resume", 512'(out_valid), 512'(0));
        start_run(1, 2, 4);
        wait_done(20);
        check_counts(2, 1, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
